// File: rtl/implication_monitor_pkg.sv
// Shared types and limits for the implication monitor: status encoding and maximum obligation delay.
package implication_monitor_pkg;

  localparam int MAX_DELAY = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_FAILED = 2'd2
  } status_e;

endpackage

// File: rtl/implication_monitor_obligation_pipe.sv
// Obligation delay line: one bit per launched cycle, oldest bit matures after DELAY edges.
// Overlapping obligations occupy distinct bits and mature independently.
module obligation_pipe #(
  parameter int DELAY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             shift_i,
  output logic [DELAY-1:0] state_o,
  output logic             matured_o
);

  logic [DELAY-1:0] sr_q, sr_d;

  // Shifting a 1-bit vector left yields zero, so DELAY=1 degenerates to a single flop.
  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = shift_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign state_o   = sr_q;
  assign matured_o = sr_q[DELAY-1];

endmodule

// File: rtl/implication_monitor.sv
// Checks (en && ante) |-> ##DELAY cons, pulsing pass/fail one cycle after maturity, with saturating counters and sticky status.
// Defining IMPLICATION_MONITOR_SVA_EN adds an inline concurrent assertion of the same property.
module implication_monitor
  import implication_monitor_pkg::*;
#(
  parameter int DELAY = 1,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             en,
  input  logic             ante,
  input  logic             cons,
  input  logic             clr,
  output logic             fail,
  output logic             pass,
  output logic             pending,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] pass_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             launch;
  logic [DELAY-1:0] obl_state;
  logic             matured;
  logic             pass_d, fail_d, pending_d;
  logic             pass_q, fail_q, pending_q;
  logic [CNT_W-1:0] pass_cnt_d, fail_cnt_d, pass_cnt_q, fail_cnt_q;
  status_e          state_d, state_q;

  assign launch = en & ante;

  obligation_pipe #(.DELAY(DELAY)) u_pipe (
    .clk_i     (CLK),
    .rst_i     (RESET),
    .shift_i   (launch),
    .state_o   (obl_state),
    .matured_o (matured)
  );

  // pending_d mirrors the pipe contents after this edge: survivors of the shift plus the new launch.
  always_comb begin
    pass_d    = matured & cons;
    fail_d    = matured & ~cons;
    pending_d = (|(obl_state << 1)) | launch;

    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (clr) begin
      pass_cnt_d = '0;
      fail_cnt_d = '0;
    end else begin
      if (pass_d && pass_cnt_q != CNT_MAX) pass_cnt_d = pass_cnt_q + 1'b1;
      if (fail_d && fail_cnt_q != CNT_MAX) fail_cnt_d = fail_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr)                     state_d = pending_d ? ST_ACTIVE : ST_IDLE;
    else if (fail_d)             state_d = ST_FAILED;
    else if (state_q != ST_FAILED) state_d = pending_d ? ST_ACTIVE : ST_IDLE;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      pending_q  <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      state_q    <= ST_IDLE;
    end else begin
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      pending_q  <= pending_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      state_q    <= state_d;
    end
  end

  assign pass     = pass_q;
  assign fail     = fail_q;
  assign pending  = pending_q;
  assign status   = state_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;

`ifdef IMPLICATION_MONITOR_SVA_EN
  a_implication: assert property (@(posedge CLK) disable iff (RESET) (en && ante) |-> ##DELAY cons);
`endif

endmodule

// File: tb/tb_implication_monitor.sv
// Directed bench for implication_monitor: three configurations, pulse scoreboard plus level checks.
module tb_implication_monitor;
  import implication_monitor_pkg::*;

  typedef struct {
    int inst;
    bit is_pass;
    int pc;
    int fc;
  } exp_t;

  logic       CLK, RESET;
  logic [2:0] en, ante, cons, clr;
  logic [2:0] pw, fw, pend;
  logic [1:0] st0, st1, st2;
  logic [7:0] pc0, fc0, pc2, fc2;
  logic [1:0] pc1, fc1;
  int         pcv[3], fcv[3];

  exp_t sbq[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  implication_monitor #(.DELAY(1), .CNT_W(8)) u_d1 (
    .CLK(CLK), .RESET(RESET), .en(en[0]), .ante(ante[0]), .cons(cons[0]), .clr(clr[0]),
    .fail(fw[0]), .pass(pw[0]), .pending(pend[0]), .status(st0), .fail_cnt(fc0), .pass_cnt(pc0));

  implication_monitor #(.DELAY(3), .CNT_W(2)) u_d3 (
    .CLK(CLK), .RESET(RESET), .en(en[1]), .ante(ante[1]), .cons(cons[1]), .clr(clr[1]),
    .fail(fw[1]), .pass(pw[1]), .pending(pend[1]), .status(st1), .fail_cnt(fc1), .pass_cnt(pc1));

  implication_monitor #(.DELAY(4), .CNT_W(8)) u_d4 (
    .CLK(CLK), .RESET(RESET), .en(en[2]), .ante(ante[2]), .cons(cons[2]), .clr(clr[2]),
    .fail(fw[2]), .pass(pw[2]), .pending(pend[2]), .status(st2), .fail_cnt(fc2), .pass_cnt(pc2));

  always_comb begin
    pcv[0] = int'(pc0); fcv[0] = int'(fc0);
    pcv[1] = int'(pc1); fcv[1] = int'(fc1);
    pcv[2] = int'(pc2); fcv[2] = int'(fc2);
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Pulse monitor: every pass/fail pulse must match the next expected event.
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (pw[i] === 1'b1 || fw[i] === 1'b1) begin
        n_cmp++;
        if (pw[i] === 1'b1 && fw[i] === 1'b1) begin
          n_bad++;
          $display("FAIL both_pulses inst=%0d pass=1 fail=1 required one-hot", i);
        end else if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pulse inst=%0d pass=%0b fail=%0b required none", i, pw[i], fw[i]);
        end else begin
          mon_e = sbq.pop_front();
          if (mon_e.inst != i || mon_e.is_pass != pw[i] || mon_e.pc != pcv[i] || mon_e.fc != fcv[i]) begin
            n_bad++;
            $display("FAIL pulse inst=%0d pass=%0b pc=%0d fc=%0d required inst=%0d pass=%0b pc=%0d fc=%0d",
                     i, pw[i], pcv[i], fcv[i], mon_e.inst, mon_e.is_pass, mon_e.pc, mon_e.fc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int inst, input bit is_pass, input int pc, input int fc);
    exp_t e;
    e.inst = inst; e.is_pass = is_pass; e.pc = pc; e.fc = fc;
    sbq.push_back(e);
  endtask

  initial begin
    bit a_v[6];
    bit c_v[6];
    a_v = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    c_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    RESET = 1'b1; en = '0; ante = '0; cons = '0; clr = '0;
    tick(); tick();
    chk("rst_pending", {29'd0, pend}, 0);
    chk("rst_pulses", {26'd0, pw, fw}, 0);
    chk("rst_status_d1", st0, ST_IDLE);
    chk("rst_status_d3", st1, ST_IDLE);
    chk("rst_cnt_d1", {pc0, fc0}, 0);
    chk("rst_cnt_d3", {pc1, fc1}, 0);
    RESET = 1'b0;

    // DELAY=1: single pass, en dropped before maturity
    en[0] = 1'b1; ante[0] = 1'b1;
    push(0, 1'b1, 1, 0);
    tick();
    en[0] = 1'b0; ante[0] = 1'b0; cons[0] = 1'b1;
    chk("d1_pending", pend[0], 1);
    chk("d1_active", st0, ST_ACTIVE);
    tick();
    cons[0] = 1'b0;
    chk("d1_idle_after", st0, ST_IDLE);
    chk("d1_pending_clear", pend[0], 0);
    tick();
    chk("d1_pass_cnt", pc0, 1);
    chk("d1_pulse_gone", pw[0], 0);

    // DELAY=3: overlapping obligations pass, fail, pass
    push(1, 1'b1, 1, 0);
    push(1, 1'b0, 1, 1);
    push(1, 1'b1, 2, 1);
    for (int k = 0; k < 6; k++) begin
      en[1] = a_v[k]; ante[1] = a_v[k]; cons[1] = c_v[k];
      if (k == 1) chk("d3_pending_mid", pend[1], 1);
      tick();
    end
    en[1] = 1'b0; ante[1] = 1'b0; cons[1] = 1'b0;
    chk("d3_status_failed", st1, ST_FAILED);
    chk("d3_fail_cnt", fc1, 1);
    chk("d3_pass_cnt", pc1, 2);
    tick();
    chk("d3_failed_sticky", st1, ST_FAILED);

    // ante while disabled launches nothing
    ante[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("d1_no_launch", pend[0], 0);
    end
    ante[0] = 1'b0;

    // clr coincident with a fail result
    en[0] = 1'b1; ante[0] = 1'b1;
    push(0, 1'b0, 0, 0);
    tick();
    en[0] = 1'b0; ante[0] = 1'b0; cons[0] = 1'b0; clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("clr_fail_status", st0, ST_IDLE);
    chk("clr_fail_cnt", fc0, 0);
    chk("clr_pass_cnt", pc0, 0);
    tick();

    // CNT_W=2: clear, then five violations saturate at 3
    clr[1] = 1'b1;
    tick();
    clr[1] = 1'b0;
    chk("d3_clr_status", st1, ST_IDLE);
    chk("d3_clr_cnt", {pc1, fc1}, 0);
    for (int k = 0; k < 5; k++) begin
      en[1] = 1'b1; ante[1] = 1'b1; cons[1] = 1'b0;
      push(1, 1'b0, 0, (k + 1 > 3) ? 3 : k + 1);
      tick();
    end
    en[1] = 1'b0; ante[1] = 1'b0;
    repeat (4) tick();
    chk("d3_fail_sat", fc1, 3);
    chk("d3_sat_status", st1, ST_FAILED);

    // DELAY=4: reset mid-flight discards the obligation, beats clr and en
    en[2] = 1'b1; ante[2] = 1'b1;
    tick();
    en[2] = 1'b0; ante[2] = 1'b0;
    tick();
    chk("d4_pending_pre", pend[2], 1);
    RESET = 1'b1; en[2] = 1'b1; ante[2] = 1'b1; clr[2] = 1'b1;
    tick();
    RESET = 1'b0; en[2] = 1'b0; ante[2] = 1'b0; clr[2] = 1'b0;
    chk("d4_pending_reset", pend[2], 0);
    chk("d4_status_reset", st2, ST_IDLE);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("d4_pending_stays", pend[2], 0);
    end

    repeat (3) tick();
    chk("sb_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/implication_monitor.md
IMPLICATION_MONITOR -- requirements
Module: implication_monitor

Interface
REQ-001 Parameter DELAY, default 1: cycles between antecedent and required consequent; legal range 1..16.
REQ-002 Parameter CNT_W, default 8: width of pass and fail counters; legal range 2..32.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset; sampled on the rising edge of CLK.
REQ-005 en  input  1  when high, a sampled antecedent launches an obligation.
REQ-006 ante  input  1  antecedent signal.
REQ-007 cons  input  1  consequent signal.
REQ-008 clr  input  1  synchronous clear of counters and sticky status.
REQ-009 fail  output  1  one-cycle pulse for each violated obligation.
REQ-010 pass  output  1  one-cycle pulse for each satisfied obligation.
REQ-011 pending  output  1  high while at least one obligation is outstanding.
REQ-012 status  output  2  monitor state encoded as the package enum.
REQ-013 fail_cnt  output  CNT_W  saturating count of violations.
REQ-014 pass_cnt  output  CNT_W  saturating count of passes.

Function
REQ-015 Edge t with en=1 and ante=1 shall launch an obligation; cons is evaluated for it at edge t+DELAY.
- ante while en=0 shall launch nothing.
- An outstanding obligation shall still be evaluated after en falls.
REQ-016 Obligations shall be held in a DELAY-deep shift register, one bit per cycle, so overlapping obligations (ante high on consecutive cycles) are each checked independently.
REQ-017 An obligation maturing at edge t+DELAY:
- with cons=1, pass shall be high during cycle t+DELAY+1;
- with cons=0, fail shall be high during cycle t+DELAY+1.
REQ-018 pass and fail shall never be high together and shall be low in every cycle without a matured obligation.
REQ-019 pending shall be registered and equal the OR of all obligation bits after the edge.
REQ-020 fail_cnt and pass_cnt shall increment by 1 with the corresponding pulse and hold at 2^CNT_W-1 (no wrap).
REQ-021 The status state machine shall have three states:
- ST_IDLE: no obligations outstanding.
- ST_ACTIVE: at least one obligation outstanding.
- ST_FAILED: entered on any violation; sticky until clr or RESET.
REQ-022 Transitions between ST_IDLE and ST_ACTIVE shall track pending; ST_FAILED shall take precedence over both.
REQ-023 clr=1 shall zero both counters and force the state to ST_IDLE or ST_ACTIVE per pending.
- clr shall not flush outstanding obligations.
- A pass or fail result coincident with clr shall still pulse but shall not be counted and shall not set ST_FAILED.
REQ-024 With DELAY=1 the block shall behave as a single-flop obligation with the same timing rules.

Reset
REQ-025 RESET shall clear all obligation bits and force:
- fail=0, pass=0, pending=0;
- status=ST_IDLE;
- fail_cnt=0, pass_cnt=0.
REQ-026 RESET asserted mid-operation shall discard all outstanding obligations with no pass or fail pulse; RESET takes priority over clr and en.

Configuration
REQ-027 Macro IMPLICATION_MONITOR_SVA_EN:
- when defined, the block shall include an inline concurrent assertion on CLK: (en && ante) |-> ##DELAY cons, disabled while RESET is high;
- when undefined, no assertion code is compiled and the RTL behaviour is identical.

Structure
REQ-028 Package implication_monitor_pkg shall hold:
- the status enum (ST_IDLE=0, ST_ACTIVE=1, ST_FAILED=2);
- constant MAX_DELAY=16.
REQ-029 The shift register shall be a sub-module obligation_pipe, with a shift-in input, a DELAY-bit state output and a matured-bit output; the counters and FSM stay in the top level.

Verification
REQ-030 DELAY=1: ante=1 and en=1 at edge 0, cons=1 at edge 1 -> pass=1 in cycle 2, pass_cnt=1, status=ST_IDLE afterwards.
REQ-031 DELAY=3: ante=1 at edges 0,1,2, cons=1,0,1 at edges 3,4,5 -> pulses pass, fail, pass in cycles 4,5,6; fail_cnt=1; pass_cnt=2; status=ST_FAILED.
REQ-032 CNT_W=2: 5 violations -> fail_cnt saturates at 3.
REQ-033 DELAY=4: ante=1 at edge 0, RESET at edge 2 -> no pulse ever occurs and pending=0 from cycle 3.
REQ-034 en=0 with ante=1 for 10 cycles -> pending=0 and no pulses; clr coincident with a fail pulse -> fail pulse seen, fail_cnt=0, status not ST_FAILED.
REQ-035 With IMPLICATION_MONITOR_SVA_EN defined, the REQ-031 stimulus shall fire the assertion exactly once.
